// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: entry layout, default register-index
// widths and the opcode constants rename uses to derive hasdest.
package rob_pkg;

  localparam int PREG_W = 6;
  localparam int AREG_W = 5;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic              valid;
    logic              complete;
    logic              hasdest;
    logic [AREG_W-1:0] ard;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] oldpd;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Reorder-buffer bus: 2-wide allocate from rename, 2 completion ports from
// execution, 2-wide retire back to the rename free pool.
// master = rename/execution side, slave = reorder buffer.
interface reorder_buffer_if import rob_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = rob_pkg::PREG_W,
  parameter int AREG_W = rob_pkg::AREG_W
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic              alloc_valid_1;
  logic              alloc_valid_2;
  logic [AREG_W-1:0] alloc_ard_1;
  logic [AREG_W-1:0] alloc_ard_2;
  logic [PREG_W-1:0] alloc_pd_1;
  logic [PREG_W-1:0] alloc_pd_2;
  logic [PREG_W-1:0] alloc_oldpd_1;
  logic [PREG_W-1:0] alloc_oldpd_2;
  logic              alloc_hasdest_1;
  logic              alloc_hasdest_2;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx_1;
  logic [IDX_W-1:0]  alloc_idx_2;

  logic              cmpl_valid_1;
  logic              cmpl_valid_2;
  logic [IDX_W-1:0]  cmpl_idx_1;
  logic [IDX_W-1:0]  cmpl_idx_2;

  logic              retire_valid_1;
  logic              retire_valid_2;
  logic [AREG_W-1:0] retire_ard_1;
  logic [AREG_W-1:0] retire_ard_2;
  logic [PREG_W-1:0] retire_pd_1;
  logic [PREG_W-1:0] retire_pd_2;
  logic              retire_free_1;
  logic              retire_free_2;
  logic [PREG_W-1:0] retire_oldpd_1;
  logic [PREG_W-1:0] retire_oldpd_2;

  logic [CNT_W-1:0]  count;

  modport master (
    output alloc_valid_1, alloc_valid_2, alloc_ard_1, alloc_ard_2,
           alloc_pd_1, alloc_pd_2, alloc_oldpd_1, alloc_oldpd_2,
           alloc_hasdest_1, alloc_hasdest_2,
           cmpl_valid_1, cmpl_valid_2, cmpl_idx_1, cmpl_idx_2,
    input  alloc_ready, alloc_idx_1, alloc_idx_2,
           retire_valid_1, retire_valid_2, retire_ard_1, retire_ard_2,
           retire_pd_1, retire_pd_2, retire_free_1, retire_free_2,
           retire_oldpd_1, retire_oldpd_2, count
  );

  modport slave (
    input  alloc_valid_1, alloc_valid_2, alloc_ard_1, alloc_ard_2,
           alloc_pd_1, alloc_pd_2, alloc_oldpd_1, alloc_oldpd_2,
           alloc_hasdest_1, alloc_hasdest_2,
           cmpl_valid_1, cmpl_valid_2, cmpl_idx_1, cmpl_idx_2,
    output alloc_ready, alloc_idx_1, alloc_idx_2,
           retire_valid_1, retire_valid_2, retire_ard_1, retire_ard_2,
           retire_pd_1, retire_pd_2, retire_free_1, retire_free_2,
           retire_oldpd_1, retire_oldpd_2, count
  );

endinterface

// File: rtl/reorder_buffer.sv
// 2-wide reorder buffer: in-order allocate, out-of-order complete,
// in-order retire. Retire returns the previous physical mapping to the
// rename free pool when the retired entry has a destination.
// Optional macro ROB_FLUSH_EN adds a 'flush' input that discards every
// entry at the edge, with priority over alloc, completion and retire.
module reorder_buffer import rob_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = rob_pkg::PREG_W,
  parameter int AREG_W = rob_pkg::AREG_W
) (
  input  logic           clk,
  input  logic           rst,
`ifdef ROB_FLUSH_EN
  input  logic           flush,
`endif
  reorder_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  cmpl_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  cmpl_d;
  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [AREG_W-1:0] ard_mem   [DEPTH];
  logic [PREG_W-1:0] pd_mem    [DEPTH];
  logic [PREG_W-1:0] oldpd_mem [DEPTH];
  logic [DEPTH-1:0]  hasdest_mem;

  logic              ready;
  logic              acc_1;
  logic              acc_2;
  logic [IDX_W-1:0]  idx_1;
  logic [IDX_W-1:0]  idx_2;
  logic [IDX_W-1:0]  head_p1;
  logic              ret_1;
  logic              ret_2;
  logic [CNT_W-1:0]  n_alloc;
  logic [CNT_W-1:0]  n_ret;
  logic              do_flush;

`ifdef ROB_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  // Ready looks only at the registered count, so a slot freed by retirement
  // this cycle is never handed out in the same cycle.
  assign ready = (count <= CNT_W'(DEPTH - 2));
  assign acc_1 = ready & bus.alloc_valid_1;
  assign acc_2 = ready & bus.alloc_valid_2;

  // Compaction: slot 2 takes tail only when slot 1 is idle.
  assign idx_1 = tail;
  assign idx_2 = bus.alloc_valid_1 ? tail + IDX_W'(1) : tail;

  // Retirement strictly in program order from the pre-edge state.
  assign head_p1 = head + IDX_W'(1);
  assign ret_1   = valid_q[head] & cmpl_q[head];
  assign ret_2   = ret_1 & valid_q[head_p1] & cmpl_q[head_p1];

  assign n_alloc = CNT_W'(acc_1) + CNT_W'(acc_2);
  assign n_ret   = CNT_W'(ret_1) + CNT_W'(ret_2);

  assign bus.alloc_ready = ready;
  assign bus.alloc_idx_1 = idx_1;
  assign bus.alloc_idx_2 = idx_2;
  assign bus.count       = count;

  // Next valid/complete bits: completion, then retire clears, then alloc.
  always_comb begin
    valid_d = valid_q;
    cmpl_d  = cmpl_q;
    if (bus.cmpl_valid_1 && valid_q[bus.cmpl_idx_1]) cmpl_d[bus.cmpl_idx_1] = 1'b1;
    if (bus.cmpl_valid_2 && valid_q[bus.cmpl_idx_2]) cmpl_d[bus.cmpl_idx_2] = 1'b1;
    if (ret_1) begin
      valid_d[head] = 1'b0;
      cmpl_d[head]  = 1'b0;
    end
    if (ret_2) begin
      valid_d[head_p1] = 1'b0;
      cmpl_d[head_p1]  = 1'b0;
    end
    if (acc_1) begin
      valid_d[idx_1] = 1'b1;
      cmpl_d[idx_1]  = 1'b0;
    end
    if (acc_2) begin
      valid_d[idx_2] = 1'b1;
      cmpl_d[idx_2]  = 1'b0;
    end
  end

  // Control state: entry status bits, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || do_flush) begin
      valid_q <= '0;
      cmpl_q  <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      valid_q <= valid_d;
      cmpl_q  <= cmpl_d;
      head    <= head + n_ret[IDX_W-1:0];
      tail    <= tail + n_alloc[IDX_W-1:0];
      count   <= count + n_alloc - n_ret;
    end
  end

  // Entry payload; meaningful only while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (acc_1) begin
      ard_mem[idx_1]     <= bus.alloc_ard_1;
      pd_mem[idx_1]      <= bus.alloc_pd_1;
      oldpd_mem[idx_1]   <= bus.alloc_oldpd_1;
      hasdest_mem[idx_1] <= bus.alloc_hasdest_1;
    end
    if (acc_2) begin
      ard_mem[idx_2]     <= bus.alloc_ard_2;
      pd_mem[idx_2]      <= bus.alloc_pd_2;
      oldpd_mem[idx_2]   <= bus.alloc_oldpd_2;
      hasdest_mem[idx_2] <= bus.alloc_hasdest_2;
    end
  end

  // Registered retire port; all fields read zero when a slot does not retire.
  always_ff @(posedge clk) begin
    if (rst || do_flush) begin
      bus.retire_valid_1 <= 1'b0;
      bus.retire_valid_2 <= 1'b0;
      bus.retire_ard_1   <= '0;
      bus.retire_ard_2   <= '0;
      bus.retire_pd_1    <= '0;
      bus.retire_pd_2    <= '0;
      bus.retire_free_1  <= 1'b0;
      bus.retire_free_2  <= 1'b0;
      bus.retire_oldpd_1 <= '0;
      bus.retire_oldpd_2 <= '0;
    end else begin
      bus.retire_valid_1 <= ret_1;
      bus.retire_valid_2 <= ret_2;
      bus.retire_ard_1   <= ret_1 ? ard_mem[head]       : '0;
      bus.retire_ard_2   <= ret_2 ? ard_mem[head_p1]    : '0;
      bus.retire_pd_1    <= ret_1 ? pd_mem[head]        : '0;
      bus.retire_pd_2    <= ret_2 ? pd_mem[head_p1]     : '0;
      bus.retire_free_1  <= ret_1 & hasdest_mem[head];
      bus.retire_free_2  <= ret_2 & hasdest_mem[head_p1];
      bus.retire_oldpd_1 <= ret_1 ? oldpd_mem[head]     : '0;
      bus.retire_oldpd_2 <= ret_2 ? oldpd_mem[head_p1]  : '0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (DEPTH 16). Stimulus changes and
// checks happen 1 time unit after each rising edge.
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH(16)) rob_bus ();

  reorder_buffer #(.DEPTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .bus  (rob_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input int v1, input int v2,
                           input int a1, input int p1, input int o1, input int h1,
                           input int a2, input int p2, input int o2, input int h2);
    rob_bus.alloc_valid_1   = 1'(v1);
    rob_bus.alloc_valid_2   = 1'(v2);
    rob_bus.alloc_ard_1     = 5'(a1);
    rob_bus.alloc_pd_1      = 6'(p1);
    rob_bus.alloc_oldpd_1   = 6'(o1);
    rob_bus.alloc_hasdest_1 = 1'(h1);
    rob_bus.alloc_ard_2     = 5'(a2);
    rob_bus.alloc_pd_2      = 6'(p2);
    rob_bus.alloc_oldpd_2   = 6'(o2);
    rob_bus.alloc_hasdest_2 = 1'(h2);
  endtask

  task automatic set_cmpl(input int v1, input int i1, input int v2, input int i2);
    rob_bus.cmpl_valid_1 = 1'(v1);
    rob_bus.cmpl_idx_1   = 4'(i1);
    rob_bus.cmpl_valid_2 = 1'(v2);
    rob_bus.cmpl_idx_2   = 4'(i2);
  endtask

  task automatic clear_in();
    set_alloc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_cmpl(0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nb;
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_count", 32'(rob_bus.count), 0);
    chk("rst_ready", 32'(rob_bus.alloc_ready), 1);
    chk("rst_rv1", 32'(rob_bus.retire_valid_1), 0);
    chk("rst_rv2", 32'(rob_bus.retire_valid_2), 0);
    chk("rst_free1", 32'(rob_bus.retire_free_1), 0);
    chk("rst_oldpd1", 32'(rob_bus.retire_oldpd_1), 0);
    rst = 1'b0;

    // dual alloc into idx 0/1
    set_alloc(1, 1, 3, 32, 3, 1, 4, 33, 4, 1);
    #1;
    chk("dual_idx1", 32'(rob_bus.alloc_idx_1), 0);
    chk("dual_idx2", 32'(rob_bus.alloc_idx_2), 1);
    tick();
    clear_in();
    chk("dual_count", 32'(rob_bus.count), 2);

    // complete idx1 first: head not complete, nothing retires
    set_cmpl(1, 1, 0, 0);
    tick();
    clear_in();
    chk("ooo_no_ret_a", 32'(rob_bus.retire_valid_1), 0);
    tick();
    chk("ooo_no_ret_b", 32'(rob_bus.retire_valid_1), 0);
    set_cmpl(1, 0, 0, 0);
    tick();
    clear_in();
    chk("lat_no_ret", 32'(rob_bus.retire_valid_1), 0);
    chk("lat_count", 32'(rob_bus.count), 2);
    tick();
    chk("ret_rv1", 32'(rob_bus.retire_valid_1), 1);
    chk("ret_rv2", 32'(rob_bus.retire_valid_2), 1);
    chk("ret_oldpd1", 32'(rob_bus.retire_oldpd_1), 3);
    chk("ret_oldpd2", 32'(rob_bus.retire_oldpd_2), 4);
    chk("ret_free1", 32'(rob_bus.retire_free_1), 1);
    chk("ret_free2", 32'(rob_bus.retire_free_2), 1);
    chk("ret_pd1", 32'(rob_bus.retire_pd_1), 32);
    chk("ret_ard2", 32'(rob_bus.retire_ard_2), 4);
    chk("ret_count", 32'(rob_bus.count), 0);
    tick();
    chk("ret_one_cycle", 32'(rob_bus.retire_valid_1), 0);

    // store-like entry at idx 2; completion on the alloc edge is ignored
    set_alloc(1, 0, 0, 40, 0, 0, 0, 0, 0, 0);
    set_cmpl(1, 2, 0, 0);
    #1;
    chk("sw_idx1", 32'(rob_bus.alloc_idx_1), 2);
    tick();
    clear_in();
    chk("sw_count", 32'(rob_bus.count), 1);
    tick();
    chk("cmpl_invalid_ign", 32'(rob_bus.retire_valid_1), 0);
    set_cmpl(1, 2, 0, 0);
    tick();
    clear_in();
    tick();
    chk("sw_rv1", 32'(rob_bus.retire_valid_1), 1);
    chk("sw_free1", 32'(rob_bus.retire_free_1), 0);
    chk("sw_rv2", 32'(rob_bus.retire_valid_2), 0);
    chk("sw_pd1", 32'(rob_bus.retire_pd_1), 40);
    chk("sw_count0", 32'(rob_bus.count), 0);

    // idx 3/4, then slot 2 alone lands at tail = 5
    set_alloc(1, 1, 5, 34, 10, 1, 6, 35, 11, 1);
    tick();
    clear_in();
    set_alloc(0, 1, 0, 0, 0, 0, 7, 50, 7, 1);
    #1;
    chk("s2_only_idx2", 32'(rob_bus.alloc_idx_2), 5);
    tick();
    clear_in();
    chk("s2_only_count", 32'(rob_bus.count), 3);
    set_cmpl(1, 3, 1, 4);
    tick();
    set_cmpl(1, 5, 1, 5);
    tick();
    clear_in();
    chk("pair_rv1", 32'(rob_bus.retire_valid_1), 1);
    chk("pair_rv2", 32'(rob_bus.retire_valid_2), 1);
    chk("pair_oldpd1", 32'(rob_bus.retire_oldpd_1), 10);
    chk("pair_oldpd2", 32'(rob_bus.retire_oldpd_2), 11);
    chk("pair_count", 32'(rob_bus.count), 1);
    tick();
    chk("same_idx_rv1", 32'(rob_bus.retire_valid_1), 1);
    chk("same_idx_rv2", 32'(rob_bus.retire_valid_2), 0);
    chk("same_idx_oldpd", 32'(rob_bus.retire_oldpd_1), 7);
    chk("same_idx_ard", 32'(rob_bus.retire_ard_1), 7);
    chk("same_idx_count", 32'(rob_bus.count), 0);

    // fill from tail 6: one single then seven duals -> count 15, tail 5
    set_alloc(1, 0, 6, 38, 6, 1, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 7; k++) begin
      base = (7 + 2 * k) % 16;
      nb   = (base + 1) % 16;
      set_alloc(1, 1, base, base + 32, base, 1, nb, nb + 32, nb, 1);
      #1;
      if (k == 4) begin
        chk("wrap_idx1", 32'(rob_bus.alloc_idx_1), 15);
        chk("wrap_idx2", 32'(rob_bus.alloc_idx_2), 0);
      end
      tick();
    end
    clear_in();
    chk("fill_count", 32'(rob_bus.count), 15);
    chk("fill_ready", 32'(rob_bus.alloc_ready), 0);
    set_alloc(1, 1, 30, 60, 30, 1, 31, 61, 31, 1);
    tick();
    clear_in();
    chk("full_ign_count", 32'(rob_bus.count), 15);
    chk("full_ign_tail", 32'(rob_bus.alloc_idx_1), 5);

    set_cmpl(1, 6, 0, 0);
    tick();
    clear_in();
    tick();
    chk("f_ret_rv1", 32'(rob_bus.retire_valid_1), 1);
    chk("f_ret_rv2", 32'(rob_bus.retire_valid_2), 0);
    chk("f_ret_oldpd", 32'(rob_bus.retire_oldpd_1), 6);
    chk("f_ret_count", 32'(rob_bus.count), 14);
    chk("f_ret_ready", 32'(rob_bus.alloc_ready), 1);
    set_alloc(1, 1, 20, 41, 45, 1, 21, 42, 46, 1);
    #1;
    chk("reuse_idx1", 32'(rob_bus.alloc_idx_1), 5);
    chk("reuse_idx2", 32'(rob_bus.alloc_idx_2), 6);
    tick();
    clear_in();
    chk("full_count", 32'(rob_bus.count), 16);
    chk("full_ready", 32'(rob_bus.alloc_ready), 0);
    set_cmpl(1, 7, 1, 8);
    tick();
    clear_in();
    tick();
    chk("full_ret_rv2", 32'(rob_bus.retire_valid_2), 1);
    chk("full_ret_old1", 32'(rob_bus.retire_oldpd_1), 7);
    chk("full_ret_old2", 32'(rob_bus.retire_oldpd_2), 8);
    chk("full_ret_count", 32'(rob_bus.count), 14);

    // reset while a retire is pending
    set_cmpl(1, 9, 1, 10);
    tick();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rv1", 32'(rob_bus.retire_valid_1), 0);
    chk("mid_rst_count", 32'(rob_bus.count), 0);
    chk("mid_rst_ready", 32'(rob_bus.alloc_ready), 1);
    set_alloc(1, 1, 1, 32, 1, 1, 2, 33, 2, 1);
    #1;
    chk("post_rst_idx1", 32'(rob_bus.alloc_idx_1), 0);
    tick();
    clear_in();
    tick();
    chk("post_rst_no_ret", 32'(rob_bus.retire_valid_1), 0);

`ifdef ROB_FLUSH_EN
    set_alloc(1, 1, 3, 34, 3, 1, 4, 35, 4, 1);
    tick();
    set_alloc(1, 1, 5, 36, 5, 1, 6, 37, 6, 1);
    tick();
    clear_in();
    chk("pre_flush_count", 32'(rob_bus.count), 6);
    set_cmpl(1, 0, 1, 1);
    tick();
    clear_in();
    flush = 1'b1;
    set_alloc(1, 1, 8, 40, 8, 1, 9, 41, 9, 1);
    tick();
    flush = 1'b0;
    clear_in();
    chk("flush_count", 32'(rob_bus.count), 0);
    chk("flush_rv1", 32'(rob_bus.retire_valid_1), 0);
    chk("flush_tail", 32'(rob_bus.alloc_idx_1), 0);
    chk("flush_ready", 32'(rob_bus.alloc_ready), 1);
    set_alloc(1, 0, 9, 42, 9, 1, 0, 0, 0, 0);
    tick();
    clear_in();
    tick();
    tick();
    chk("flush_no_stale", 32'(rob_bus.retire_valid_1), 0);
    chk("flush_new_count", 32'(rob_bus.count), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
